// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, queue depth and arbitration source encodings
package cdb_arbiter_pkg;
  localparam int CDB_QUEUE_DEPTH = 4;
  localparam int CDB_ROB_IDX_W = 4;
  localparam int CDB_DATA_W = 32;
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: sync FIFO (push/pop/flush, full/empty, head) with enable freezing all state
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (!rst && en && !flush && do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || (en && flush)) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else if (en) begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin ALU/LSB result queues onto a registered CDB; CDB_BYPASS_EN enables 1-cycle bypass when idle
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH = CDB_QUEUE_DEPTH,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 roll_back,
  input  logic                 alu_in_en,
  input  logic [ROB_IDX_W-1:0] alu_rob_idx_in,
  input  logic [DATA_W-1:0]    alu_val_in,
  output logic                 alu_full,
  input  logic                 lsb_in_en,
  input  logic [ROB_IDX_W-1:0] lsb_rob_idx_in,
  input  logic [DATA_W-1:0]    lsb_val_in,
  output logic                 lsb_full,
  output logic                 cdb_en,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [DATA_W-1:0]    cdb_val
);
  localparam int W = ROB_IDX_W + DATA_W;
  logic [W-1:0] alu_head, lsb_head, sel_word;
  logic alu_empty, lsb_empty, alu_push, lsb_push;
  logic gnt_alu, gnt_lsb, byp_alu, byp_lsb, sel_alu, sel_any, prio;
  assign gnt_alu = !alu_empty && (lsb_empty || prio == CDB_SRC_ALU);
  assign gnt_lsb = !lsb_empty && (alu_empty || prio == CDB_SRC_LSB);
`ifdef CDB_BYPASS_EN
  assign byp_alu = alu_in_en && alu_empty && lsb_empty;
  assign byp_lsb = lsb_in_en && !alu_in_en && alu_empty && lsb_empty;
`else
  assign byp_alu = 1'b0;
  assign byp_lsb = 1'b0;
`endif
  assign alu_push = alu_in_en && !byp_alu;
  assign lsb_push = lsb_in_en && !byp_lsb;
  assign sel_alu = gnt_alu || byp_alu;
  assign sel_any = sel_alu || gnt_lsb || byp_lsb;
  assign sel_word = gnt_alu ? alu_head : gnt_lsb ? lsb_head :
                    byp_alu ? {alu_rob_idx_in, alu_val_in} : {lsb_rob_idx_in, lsb_val_in};
  cdb_fifo #(.DEPTH(QUEUE_DEPTH), .W(W)) u_alu_q (
    .clk(clk), .rst(rst_in), .en(rdy_in), .flush(roll_back), .push(alu_push), .pop(gnt_alu),
    .din({alu_rob_idx_in, alu_val_in}), .full(alu_full), .empty(alu_empty), .head(alu_head)
  );
  cdb_fifo #(.DEPTH(QUEUE_DEPTH), .W(W)) u_lsb_q (
    .clk(clk), .rst(rst_in), .en(rdy_in), .flush(roll_back), .push(lsb_push), .pop(gnt_lsb),
    .din({lsb_rob_idx_in, lsb_val_in}), .full(lsb_full), .empty(lsb_empty), .head(lsb_head)
  );
  always_ff @(posedge clk) begin
    if (rst_in) begin
      cdb_en <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_val <= '0;
      prio <= CDB_SRC_ALU;
    end else if (rdy_in) begin
      if (roll_back) begin
        cdb_en <= 1'b0;
        prio <= CDB_SRC_ALU;
      end else begin
        cdb_en <= sel_any;
        if (sel_any) begin
          {cdb_rob_idx, cdb_val} <= sel_word;
          prio <= sel_alu ? CDB_SRC_LSB : CDB_SRC_ALU;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_in, rdy_in, roll_back;
  logic alu_in_en, lsb_in_en, alu_full, lsb_full, cdb_en;
  logic [3:0] alu_rob_idx_in, lsb_rob_idx_in, cdb_rob_idx;
  logic [31:0] alu_val_in, lsb_val_in, cdb_val;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  cdb_arbiter dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .alu_in_en(alu_in_en), .alu_rob_idx_in(alu_rob_idx_in), .alu_val_in(alu_val_in), .alu_full(alu_full),
    .lsb_in_en(lsb_in_en), .lsb_rob_idx_in(lsb_rob_idx_in), .lsb_val_in(lsb_val_in), .lsb_full(lsb_full),
    .cdb_en(cdb_en), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    rdy_in = 1'b1;
    roll_back = 1'b0;
    alu_in_en = 1'b0;
    lsb_in_en = 1'b0;
    alu_rob_idx_in = '0;
    lsb_rob_idx_in = '0;
    alu_val_in = '0;
    lsb_val_in = '0;
  endtask
  task automatic do_reset;
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask
  task automatic push_both(input int k);
    alu_in_en = 1'b1;
    alu_rob_idx_in = 4'(k);
    alu_val_in = 32'hA0 + 32'(k);
    lsb_in_en = 1'b1;
    lsb_rob_idx_in = 4'(k);
    lsb_val_in = 32'hB0 + 32'(k);
  endtask
  task automatic test_reset;
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    checks++;
    if ({cdb_en, cdb_rob_idx, cdb_val, alu_full, lsb_full} !== '0) begin
      errors++;
      $display("FAIL reset_state: got en=%0b idx=%0d val=%h af=%0b lf=%0b, want all 0", cdb_en, cdb_rob_idx, cdb_val, alu_full, lsb_full);
    end
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({cdb_en, cdb_rob_idx, cdb_val, alu_full, lsb_full} !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got en=%0b idx=%0d val=%h af=%0b lf=%0b, want all 0", i, cdb_en, cdb_rob_idx, cdb_val, alu_full, lsb_full);
      end
    end
  endtask
  task automatic test_single_push;
    do_reset();
    alu_in_en = 1'b1;
    alu_rob_idx_in = 4'd3;
    alu_val_in = 32'h0000_00AA;
    tick();
    alu_in_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      checks++;
      if (cdb_en !== (c == LAT)) begin
        errors++;
        $display("FAIL single_en_c%0d: got %0b want %0b", c, cdb_en, (c == LAT));
      end
      if (c == LAT) begin
        checks++;
        if (cdb_rob_idx !== 4'd3 || cdb_val !== 32'hAA) begin
          errors++;
          $display("FAIL single_data: got idx=%0d val=%h want idx=3 val=000000aa", cdb_rob_idx, cdb_val);
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    int ai, li, got;
    logic full_seen;
    do_reset();
    ai = 0;
    li = 0;
    got = 0;
    full_seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      alu_in_en = (ai < 8) && !alu_full;
      alu_rob_idx_in = 4'(ai);
      alu_val_in = 32'h100 + 32'(ai);
      lsb_in_en = (li < 8) && !lsb_full;
      lsb_rob_idx_in = 4'(8 + li);
      lsb_val_in = 32'h100 + 32'(8 + li);
      tick();
      if (alu_in_en) ai++;
      if (lsb_in_en) li++;
      if (alu_full || lsb_full) full_seen = 1'b1;
      if (cdb_en) begin
        int e;
        e = (got % 2 == 0) ? got / 2 : 8 + got / 2;
        checks++;
        if (got >= 16 || cdb_rob_idx !== 4'(e) || cdb_val !== 32'h100 + 32'(e)) begin
          errors++;
          $display("FAIL b2b_order%0d: got idx=%0d val=%h want idx=%0d val=%h", got, cdb_rob_idx, cdb_val, e, 32'h100 + 32'(e));
        end
        got++;
      end
    end
    idle_inputs();
    checks++;
    if (got !== 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d broadcasts want 16", got);
    end
    checks++;
    if (full_seen !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full_seen: got %0b want 1", full_seen);
    end
  endtask
  task automatic test_full_drop;
    logic [31:0] exp_val [14] = '{32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3, 32'hA4,
                                  32'hB4, 32'hA5, 32'hB5, 32'hA6, 32'hB6, 32'hA7, 32'hB8};
    logic [31:0] rec [32];
    int n;
    do_reset();
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 8) push_both(k);
      else idle_inputs();
      tick();
      if (cdb_en && n < 32) begin
        rec[n] = cdb_val;
        checks++;
        if (cdb_rob_idx !== cdb_val[3:0]) begin
          errors++;
          $display("FAIL drop_idx%0d: got idx=%0d want %0d", n, cdb_rob_idx, cdb_val[3:0]);
        end
        n++;
      end
      if (k >= 6 && k <= 8) begin
        checks++;
        if (alu_full !== (k == 7) || lsb_full !== (k != 7)) begin
          errors++;
          $display("FAIL full_flags_e%0d: got af=%0b lf=%0b want af=%0b lf=%0b", k, alu_full, lsb_full, (k == 7), (k != 7));
        end
      end
    end
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL drop_count: got %0d broadcasts want 14", n);
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (i >= n || rec[i] !== exp_val[i]) begin
        errors++;
        $display("FAIL drop_seq%0d: got %h want %h", i, (i < n) ? rec[i] : 32'hx, exp_val[i]);
      end
    end
  endtask
  task automatic test_roll_back;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push_both(k);
      tick();
    end
    checks++;
    if (cdb_en !== 1'b1 || cdb_val !== 32'hB2) begin
      errors++;
      $display("FAIL rb_pre: got en=%0b val=%h want en=1 val=000000b2", cdb_en, cdb_val);
    end
    idle_inputs();
    roll_back = 1'b1;
    alu_in_en = 1'b1;
    alu_rob_idx_in = 4'd9;
    alu_val_in = 32'hA9;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cdb_en !== 1'b0 || alu_full !== 1'b0 || lsb_full !== 1'b0) begin
        errors++;
        $display("FAIL rb_empty%0d: got en=%0b val=%h af=%0b lf=%0b want en=0 af=0 lf=0", i, cdb_en, cdb_val, alu_full, lsb_full);
      end
      tick();
    end
    alu_in_en = 1'b1;
    alu_rob_idx_in = 4'd6;
    alu_val_in = 32'h66;
    tick();
    alu_in_en = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (c > 1) tick();
      checks++;
      if (cdb_en !== (c == LAT) || (c == LAT && (cdb_rob_idx !== 4'd6 || cdb_val !== 32'h66))) begin
        errors++;
        $display("FAIL rb_after_c%0d: got en=%0b idx=%0d val=%h want en=%0b idx=6 val=00000066", c, cdb_en, cdb_rob_idx, cdb_val, (c == LAT));
      end
    end
  endtask
  task automatic test_freeze;
    logic [3:0] exp_i [4] = '{4'd6, 4'd7, 4'd7, 4'd7};
    logic exp_e [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int k = 4; k <= 6; k++) begin
      alu_in_en = 1'b1;
      alu_rob_idx_in = 4'(k);
      alu_val_in = 32'(k * 17);
      tick();
    end
    checks++;
    if (cdb_en !== 1'b1 || cdb_rob_idx !== 4'd5 || cdb_val !== 32'h55) begin
      errors++;
      $display("FAIL frz_pre: got en=%0b idx=%0d val=%h want en=1 idx=5 val=00000055", cdb_en, cdb_rob_idx, cdb_val);
    end
    rdy_in = 1'b0;
    alu_rob_idx_in = 4'd15;
    alu_val_in = 32'hFF;
    lsb_in_en = 1'b1;
    lsb_rob_idx_in = 4'd14;
    lsb_val_in = 32'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cdb_en !== 1'b1 || cdb_rob_idx !== 4'd5 || cdb_val !== 32'h55 || alu_full !== 1'b0) begin
        errors++;
        $display("FAIL frz_hold%0d: got en=%0b idx=%0d val=%h af=%0b want en=1 idx=5 val=00000055 af=0", i, cdb_en, cdb_rob_idx, cdb_val, alu_full);
      end
    end
    idle_inputs();
    alu_in_en = 1'b1;
    alu_rob_idx_in = 4'd7;
    alu_val_in = 32'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      alu_in_en = 1'b0;
      checks++;
      if (cdb_en !== exp_e[i] || cdb_rob_idx !== exp_i[i] || cdb_val !== 32'(exp_i[i] * 17)) begin
        errors++;
        $display("FAIL frz_resume%0d: got en=%0b idx=%0d val=%h want en=%0b idx=%0d val=%h", i, cdb_en, cdb_rob_idx, cdb_val, exp_e[i], exp_i[i], 32'(exp_i[i] * 17));
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_full_drop();
    test_roll_back();
    test_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares one registered common data bus (CDB) between the two result producers, the ALU/RS and the LSB.
- Each producer pushes {rob_idx, val} into its own small FIFO. A round-robin arbiter pops at most one entry per cycle and drives the ROB/RS/LSB write-back port.
- Sits between the execution units and the reorder buffer.
- Flushed by the ROB's roll_back.

Parameters:
QUEUE_DEPTH, 4, entries per producer FIFO (power of two, >=2)
ROB_IDX_W, 4, ROB index width (matches ROB_SIZE 16)
DATA_W, 32, result value width

Ports:
clk  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low = freeze all state
roll_back  in  1  misprediction flush from ROB
alu_in_en  in  1  ALU result valid (push)
alu_rob_idx_in  in  ROB_IDX_W  ALU result ROB index
alu_val_in  in  DATA_W  ALU result value
alu_full  out  1  ALU queue full; producer must not push
lsb_in_en  in  1  LSB result valid (push)
lsb_rob_idx_in  in  ROB_IDX_W  LSB result ROB index
lsb_val_in  in  DATA_W  LSB result value
lsb_full  out  1  LSB queue full
cdb_en  out  1  broadcast valid, registered
cdb_rob_idx  out  ROB_IDX_W  broadcast ROB index, registered
cdb_val  out  DATA_W  broadcast value, registered

Behaviour:
- Reset (rst_in=1 at posedge):
  - Both queues empty; cdb_en=0, cdb_rob_idx=0, cdb_val=0.
  - prio=0 (ALU preferred); alu_full=lsb_full=0.
- rdy_in=0: no push, pop, prio change or output change; outputs hold their last values.
- Order of precedence at each posedge: rst_in > !rdy_in > roll_back > normal.
- roll_back=1 (rdy_in=1):
  - Both queues emptied; cdb_en<=0; prio<=0.
  - Pushes in the same cycle are discarded.
- Push:
  - x_in_en && !x_full writes the tail; count+1.
  - x_in_en while x_full: entry dropped, queue unchanged (protocol violation; bench flags it).
- x_full = (count_x == QUEUE_DEPTH), decoded combinationally from registered count. It is not relieved by a same-cycle pop.
- Grant, evaluated on queue heads at the start of the cycle:
  - Only ALU non-empty -> ALU.
  - Only LSB non-empty -> LSB.
  - Both non-empty -> ALU if prio=0, else LSB.
  - After any grant, prio <= (granted==ALU ? 1 : 0).
- Pop: the granted head is popped; cdb_en<=1, cdb_rob_idx/cdb_val <= head fields. With no grant, cdb_en<=0; idx/val hold.
- Latency: push at edge N -> cdb_en high in the cycle after edge N+1 (2 cycles) when uncontested. Each queue is FIFO-ordered.
- Simultaneous push and pop on the same queue: count unchanged; a pop from a single-entry queue with concurrent push leaves the new entry as head.
- Pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.
- Throughput: 1 result/cycle total. Under saturation ALU and LSB alternate strictly.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined:
  - If the target queue is empty, no entry from either queue is granted this cycle, and exactly one x_in_en is high, that result goes directly to the cdb registers at this edge (latency 1) and is not enqueued.
  - Both in_en with both queues empty: ALU bypasses, LSB enqueues.
  - A bypass counts as a grant for the prio update.
- Undefined: all results pass through the queues; latency is always >=2.

Decomposition:
- Widths come from the shared `ROB_IDX_WIDTH` / `DATA_WIDTH` macros in param.v. Add CDB_QUEUE_DEPTH and source encodings CDB_SRC_ALU=0, CDB_SRC_LSB=1 there.
- One sub-module, cdb_fifo: a parameterised sync FIFO with push/pop/flush/full/empty/head, instantiated twice.
- Arbiter and output register live in the top module.

Test Plan:
- Reset then idle: cdb_en=0, idx=0, val=0, alu_full=lsb_full=0 for 10 cycles.
- Single ALU push (idx=3, val=0x0000_00AA) -> cdb_en=1, idx=3, val=0xAA two cycles later (one cycle with CDB_BYPASS_EN); high for exactly 1 cycle.
- Both push every cycle for 8 cycles (ALU idx 0..7, LSB idx 8..15) -> CDB order 0,8,1,9,2,10,...; no loss. Full flags assert once the queues back up; producers honour full.
- 4 ALU pushes with no pops possible (LSB pushing, prio forced) -> alu_full=1 after the 4th; a 5th push while full is dropped and flagged.
- Queues holding 3 entries each, roll_back=1 with alu_in_en=1 -> next cycle cdb_en=0, both queues empty, the same-cycle push absent; the next push has latency 2.
- rdy_in=0 for 5 cycles mid-stream with cdb_en=1, idx=5 -> outputs frozen; on resume the sequence continues with no skipped or duplicated index.
